// File: rtl/alu_result_stage.sv
// ALU result register stage: NZCV derivation, status register, writeback handshake.
// Define ALU_RES_SKID_EN for a 2-entry skid buffer with a registered in_ready.
module alu_result_stage #(
    parameter int unsigned BITS  = 16,
    parameter int unsigned RA_W  = 3,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_sel,
    input  logic [BITS-1:0]  in_out,
    input  logic             in_cout,
    input  logic             in_statv,
    input  logic [RA_W-1:0]  in_rd,
    input  logic             in_setf,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [RA_W-1:0]  wb_rd,
    output logic [BITS-1:0]  wb_data,
    output logic [3:0]       flags,
    output logic [CNT_W-1:0] retired
);

    logic             accept;
    logic             xfer;
    logic             sel_unused;
    logic [3:0]       flags_q, flags_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             main_v_q, main_v_d;
    logic [BITS-1:0]  main_data_q, main_data_d;
    logic [RA_W-1:0]  main_rd_q, main_rd_d;

    // Only Sel[2] (logic vs arithmetic) affects flag derivation.
    assign sel_unused = ^in_sel[1:0];

    assign accept = in_valid & in_ready & ~flush;
    assign xfer   = main_v_q & wb_ready;

    always_comb begin
        flags_d = flags_q;
        if (accept && in_setf) begin
            flags_d = {in_out[BITS-1], (in_out == '0),
                       ~in_sel[2] & in_cout, ~in_sel[2] & in_statv};
        end
    end

    assign retired_d = retired_q + {{(CNT_W-1){1'b0}}, xfer};

`ifdef ALU_RES_SKID_EN
    logic             skid_v_q, skid_v_d;
    logic [BITS-1:0]  skid_data_q, skid_data_d;
    logic [RA_W-1:0]  skid_rd_q, skid_rd_d;

    assign in_ready = ~skid_v_q;

    // Main register refills from the skid slot first to keep ordering;
    // the skid slot only fills while main is stalled.
    always_comb begin
        main_v_d    = main_v_q;
        main_data_d = main_data_q;
        main_rd_d   = main_rd_q;
        skid_v_d    = skid_v_q;
        skid_data_d = skid_data_q;
        skid_rd_d   = skid_rd_q;
        if (flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (!main_v_q || xfer) begin
            if (skid_v_q) begin
                main_v_d    = 1'b1;
                main_data_d = skid_data_q;
                main_rd_d   = skid_rd_q;
                skid_v_d    = accept;
                if (accept) begin
                    skid_data_d = in_out;
                    skid_rd_d   = in_rd;
                end
            end else begin
                main_v_d = accept;
                if (accept) begin
                    main_data_d = in_out;
                    main_rd_d   = in_rd;
                end
            end
        end else if (accept) begin
            skid_v_d    = 1'b1;
            skid_data_d = in_out;
            skid_rd_d   = in_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_v_q    <= 1'b0;
            skid_data_q <= '0;
            skid_rd_q   <= '0;
        end else begin
            skid_v_q    <= skid_v_d;
            skid_data_q <= skid_data_d;
            skid_rd_q   <= skid_rd_d;
        end
    end
`else
    assign in_ready = ~main_v_q | wb_ready;

    always_comb begin
        main_v_d    = main_v_q;
        main_data_d = main_data_q;
        main_rd_d   = main_rd_q;
        if (flush) begin
            main_v_d = 1'b0;
        end else if (accept) begin
            main_v_d    = 1'b1;
            main_data_d = in_out;
            main_rd_d   = in_rd;
        end else if (xfer) begin
            main_v_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_v_q    <= 1'b0;
            main_data_q <= '0;
            main_rd_q   <= '0;
            flags_q     <= '0;
            retired_q   <= '0;
        end else begin
            main_v_q    <= main_v_d;
            main_data_q <= main_data_d;
            main_rd_q   <= main_rd_d;
            flags_q     <= flags_d;
            retired_q   <= retired_d;
        end
    end

    assign wb_valid = main_v_q;
    assign wb_data  = main_data_q;
    assign wb_rd    = main_rd_q;
    assign flags    = flags_q;
    assign retired  = retired_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: table vectors, directed corner
// sequences and random traffic against a queue-based reference model.
module tb_alu_result_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_sel;
    logic [15:0] in_out;
    logic        in_cout;
    logic        in_statv;
    logic [2:0]  in_rd;
    logic        in_setf;
    logic        wb_valid;
    logic        wb_ready;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
    logic [3:0]  flags;
    logic [3:0]  retired;

    alu_result_stage #(.BITS(16), .RA_W(3), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
        .in_out(in_out), .in_cout(in_cout), .in_statv(in_statv),
        .in_rd(in_rd), .in_setf(in_setf),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
        .wb_data(wb_data), .flags(flags), .retired(retired)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: FIFO of pending results {rd, data}, status flags, count.
    logic [18:0] q[$];
    logic [3:0]  m_flags;
    int          m_ret;

    typedef struct {
        logic [2:0]  sel;
        logic [15:0] d;
        logic        c;
        logic        v;
        logic        setf;
        logic [3:0]  exp_flags;
    } vec_t;
    vec_t tbl[8];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic int cap_limit();
`ifdef ALU_RES_SKID_EN
        return 2;
`else
        return 1;
`endif
    endfunction

    function automatic logic exp_ready(logic wr);
`ifdef ALU_RES_SKID_EN
        return q.size() < 2;
`else
        return (q.size() == 0) || wr;
`endif
    endfunction

    task automatic model_reset();
        q.delete();
        m_flags = 4'b0000;
        m_ret   = 0;
    endtask

    // Drives one cycle at a negedge, checks all outputs, advances the model.
    task automatic step(input logic v, input logic [2:0] sel, input logic [15:0] d,
                        input logic c, input logic sv, input logic [2:0] rd,
                        input logic setf, input logic wr, input logic fl);
        logic er, xf, acc;
        in_valid = v;   in_sel = sel;   in_out = d;  in_cout = c;
        in_statv = sv;  in_rd = rd;     in_setf = setf;
        wb_ready = wr;  flush = fl;
        #1;
        er = exp_ready(wr);
        chk("in_ready", {31'd0, in_ready}, {31'd0, er});
        chk("wb_valid", {31'd0, wb_valid}, {31'd0, q.size() > 0});
        if (q.size() > 0) begin
            chk("wb_data", {16'd0, wb_data}, {16'd0, q[0][15:0]});
            chk("wb_rd", {29'd0, wb_rd}, {29'd0, q[0][18:16]});
        end
        chk("flags", {28'd0, flags}, {28'd0, m_flags});
        chk("retired", {28'd0, retired}, m_ret % 16);
        xf  = (q.size() > 0) && wr;
        acc = v && er && !fl;
        if (xf) begin
            void'(q.pop_front());
            m_ret++;
        end
        if (fl) q.delete();
        else if (acc) q.push_back({rd, d});
        if (acc && setf)
            m_flags = {d[15], d == 16'd0, sel[2] ? 1'b0 : c, sel[2] ? 1'b0 : sv};
        @(negedge clk);
    endtask

    task automatic idle(input logic wr);
        step(1'b0, 3'b000, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0, wr, 1'b0);
    endtask

    initial begin
        tbl[0] = '{3'b001, 16'h8000, 1'b0, 1'b1, 1'b1, 4'b1001};
        tbl[1] = '{3'b100, 16'h0000, 1'b1, 1'b1, 1'b1, 4'b0100};
        tbl[2] = '{3'b000, 16'h1234, 1'b1, 1'b0, 1'b1, 4'b0010};
        tbl[3] = '{3'b100, 16'h00ff, 1'b1, 1'b1, 1'b0, 4'b0010};
        tbl[4] = '{3'b011, 16'hffff, 1'b1, 1'b1, 1'b1, 4'b1011};
        tbl[5] = '{3'b110, 16'hffff, 1'b1, 1'b1, 1'b1, 4'b1000};
        tbl[6] = '{3'b100, 16'h0000, 1'b1, 1'b1, 1'b0, 4'b1000};
        tbl[7] = '{3'b010, 16'h0000, 1'b1, 1'b0, 1'b1, 4'b0110};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_sel = '0; in_out = '0;
        in_cout = 1'b0; in_statv = 1'b0; in_rd = '0; in_setf = 1'b0; wb_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_wb_data", {16'd0, wb_data}, 32'd0);
        chk("rst_wb_rd", {29'd0, wb_rd}, 32'd0);
        chk("rst_flags", {28'd0, flags}, 32'd0);
        chk("rst_retired", {28'd0, retired}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Flag table, back-to-back with writeback always ready.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, tbl[i].sel, tbl[i].d, tbl[i].c, tbl[i].v, 3'(i), tbl[i].setf, 1'b1, 1'b0);
            chk("tbl_flags", {28'd0, flags}, {28'd0, tbl[i].exp_flags});
            chk("tbl_data", {16'd0, wb_data}, {16'd0, tbl[i].d});
        end
        idle(1'b1);
        chk("tbl_retired", {28'd0, retired}, 32'd8);

        // Backpressure: three offered results, hold, then in-order drain.
        step(1'b1, 3'b000, 16'hA001, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'b000, 16'hA002, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'b000, 16'hA003, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0);
        chk("bp_hold_data", {16'd0, wb_data}, 32'hA001);
        chk("bp_depth", q.size(), cap_limit());
        in_valid = 1'b1; wb_ready = 1'b0; #1;
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        repeat (3) idle(1'b1);
        chk("bp_drained", {31'd0, wb_valid}, 32'd0);

        // Flush with a full buffer and a same-cycle input.
        step(1'b1, 3'b000, 16'hB001, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0);
        step(1'b1, 3'b000, 16'hB002, 1'b0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0);
        step(1'b1, 3'b000, 16'h0000, 1'b1, 1'b1, 3'd6, 1'b1, 1'b0, 1'b1);
        chk("fl_valid", {31'd0, wb_valid}, 32'd0);
        chk("fl_flags", {28'd0, flags}, 32'h8);
        repeat (2) idle(1'b1);

        // Flush coinciding with a transfer: that transfer still retires.
        step(1'b1, 3'b000, 16'hC001, 1'b0, 1'b0, 3'd7, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'b000, 16'hC002, 1'b0, 1'b0, 3'd1, 1'b0, 1'b1, 1'b1);
        chk("fl_xfer_retired", {28'd0, retired}, (m_ret % 16));
        idle(1'b1);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic [15:0] d;
            d = ($urandom % 8 == 0) ? 16'h0000 : 16'($urandom);
            step(($urandom % 4) != 0, 3'($urandom), d, 1'($urandom), 1'($urandom),
                 3'($urandom), 1'($urandom), ($urandom % 3) != 0, ($urandom % 25) == 0);
        end

        // Asynchronous reset mid-stream with a result pending.
        step(1'b1, 3'b000, 16'h8001, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0);
        step(1'b1, 3'b000, 16'h8002, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, wb_valid}, 32'd0);
        chk("mid_rst_flags", {28'd0, flags}, 32'd0);
        chk("mid_rst_retired", {28'd0, retired}, 32'd0);
        chk("mid_rst_data", {16'd0, wb_data}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Counter wrap: 17 transfers on a 4-bit counter.
        for (int i = 0; i < 17; i++)
            step(1'b1, 3'b000, 16'(i + 1), 1'b0, 1'b0, 3'(i), 1'b0, 1'b1, 1'b0);
        idle(1'b1);
        chk("wrap_retired", {28'd0, retired}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
